// File: rtl/spram_fifo_pkg.sv
// Shared types for the single-port-RAM FIFO scheduler.
//   grant_e    : per-cycle owner of the RAM port (or the bypass path)
//   WBUF_DEPTH : entries in the write buffer that sits in front of the RAM
package spram_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    BYPASS,
    WR,
    FORCE_WR
  } grant_e;

  localparam int unsigned WBUF_DEPTH = 2;

endpackage

// File: rtl/spram_fifo_wbuf.sv
// Two-entry write buffer holding the newest FIFO entries until the RAM port
// is free to absorb them. Entry 0 is always the head (oldest).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   push     : store wdata behind the current contents
//   pop      : drop the head entry
//   wdata    : data to store
//   head     : oldest stored entry
//   cnt      : number of stored entries (0..2)
module spram_fifo_wbuf
  import spram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            cnt
);

  localparam logic [1:0] FULL_CNT = 2'(WBUF_DEPTH);

  logic [DATA_WIDTH-1:0] ent0_q;
  logic [DATA_WIDTH-1:0] ent1_q;
  logic [1:0]            cnt_q;
  logic                  eff_push;
  logic                  eff_pop;

  // Requests that cannot be honoured are dropped so the entries never corrupt.
  assign eff_push = push && (cnt_q != FULL_CNT);
  assign eff_pop  = pop && (cnt_q != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({eff_push, eff_pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= wdata;
          else               ent1_q <= wdata;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: the count stays, contents shift.
          if (cnt_q == 2'd1) begin
            ent0_q <= wdata;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/spram_fifo_sched.sv
// FIFO built on an external single-port RAM with a 1-cycle synchronous read.
// Pushes land in a 2-entry write buffer; the buffer drains into the RAM
// whenever the port is not needed for a read. A pop is served from the RAM
// when it holds entries, otherwise straight from the write-buffer head.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   wen, wdata, full: push request, push data, push refused
//   ren, empty      : pop request, no stored entries
//   rbusy           : pop refused because the buffer must flush to RAM
//   rdata, rvalid   : pop data, valid one cycle after an accepted pop
//   count           : entries held in RAM plus write buffer
//   ram_*           : single-port RAM interface
module spram_fifo_sched
  import spram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  input  logic                  ren,
  output logic                  empty,
  output logic                  rbusy,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH:0]   ram_cnt_q;

  logic [1:0]            wbuf_cnt;
  logic [DATA_WIDTH-1:0] wbuf_head;
  logic                  wbuf_pop;

  logic                  push_acc;
  logic                  pop_acc;
  logic                  bypass_pop;
  logic                  ram_wr;
  grant_e                grant;

  logic                  vld_p1;
  logic                  src_ram_p1;
  logic [DATA_WIDTH-1:0] byp_data_p1;

  assign count    = ram_cnt_q + (ADDR_WIDTH + 1)'(wbuf_cnt);
  assign full     = (count == DEPTH_CNT) || (wbuf_cnt == 2'd2);
  assign empty    = (count == '0);
  assign rbusy    = (wbuf_cnt == 2'd2) && (ram_cnt_q != '0);

  assign push_acc = wen && !full;
  assign pop_acc  = ren && !empty && !rbusy;

  // With an empty RAM the oldest entry is the buffer head, whatever the grant.
  assign bypass_pop = pop_acc && (ram_cnt_q == '0);

  spram_fifo_wbuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wbuf (
    .clk  (clk),
    .rst  (rst),
    .push (push_acc),
    .pop  (wbuf_pop),
    .wdata(wdata),
    .head (wbuf_head),
    .cnt  (wbuf_cnt)
  );

  // Stage p0: RAM arbitration from registered state and this cycle's requests.
  always_comb begin
    grant = IDLE;
    if (wbuf_cnt == 2'd2)                      grant = FORCE_WR;
    else if (pop_acc && (ram_cnt_q != '0))     grant = RD;
    else if (pop_acc)                          grant = BYPASS;
    else if (wbuf_cnt != 2'd0)                 grant = WR;
  end

  assign ram_wr   = (grant == WR) || (grant == FORCE_WR);
  assign wbuf_pop = ram_wr || (grant == BYPASS);

  assign ram_en    = ram_wr || (grant == RD);
  assign ram_we    = ram_wr;
  assign ram_addr  = (grant == RD) ? rd_ptr_q : (ram_wr ? wr_ptr_q : '0);
  assign ram_wdata = ram_wr ? wbuf_head : '0;

  // A forced write that coincides with a pop on an empty RAM writes the head
  // and hands it out in the same cycle: both pointers advance and the RAM
  // occupancy is unchanged, so the written slot is already consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      ram_cnt_q <= '0;
    end else begin
      if (ram_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if ((grant == RD) || ((grant == FORCE_WR) && bypass_pop))
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case (grant)
        RD:       ram_cnt_q <= ram_cnt_q - CNT_ONE;
        WR:       ram_cnt_q <= ram_cnt_q + CNT_ONE;
        FORCE_WR: if (!bypass_pop) ram_cnt_q <= ram_cnt_q + CNT_ONE;
        default:  ;
      endcase
    end
  end

  // Stage p1: read response, one cycle after the accepted pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      src_ram_p1 <= 1'b0;
    end else begin
      vld_p1     <= pop_acc;
      src_ram_p1 <= (grant == RD);
    end
  end

  always_ff @(posedge clk) begin
    if (bypass_pop) byp_data_p1 <= wbuf_head;
  end

  assign rvalid = vld_p1;
  assign rdata  = vld_p1 ? (src_ram_p1 ? ram_rdata : byp_data_p1) : '0;

endmodule

// File: tb/tb_spram_fifo_sched.sv
module tb_spram_fifo_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       wen;
  logic [7:0] wdata;
  logic       full;
  logic       ren;
  logic       empty;
  logic       rbusy;
  logic [7:0] rdata;
  logic       rvalid;
  logic [5:0] count;
  logic       ram_en;
  logic       ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  int checks = 0;
  int errors = 0;
  int rv_events = 0;

  logic [7:0] expq[$];
  logic [7:0] mem[32];

  // Snapshot of combinational outputs taken mid-cycle in step().
  logic       s_en, s_we, s_full, s_empty, s_rbusy, s_pa, s_pp;
  logic [4:0] s_addr;
  logic [7:0] s_wdata;
  logic [5:0] s_count;

  always #5 clk = ~clk;

  spram_fifo_sched dut (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .wdata    (wdata),
    .full     (full),
    .ren      (ren),
    .empty    (empty),
    .rbusy    (rbusy),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .count    (count),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Behavioural single-port RAM, 1-cycle synchronous read.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // Scoreboard: every rvalid must carry the oldest accepted push.
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      rv_events++;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected rdata=%h with no entry expected", rdata);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL pop_data got=%h exp=%h", rdata, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    @(negedge clk);
    wen = w; wdata = d; ren = r;
    #1;
    s_en = ram_en; s_we = ram_we; s_addr = ram_addr; s_wdata = ram_wdata;
    s_full = full; s_empty = empty; s_rbusy = rbusy; s_count = count;
    s_pa = w && !full;
    s_pp = r && !empty && !rbusy;
    if (s_pa) expq.push_back(d);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!empty && n < 200) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout count=%0d", count);
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain_leftover got=%0d entries exp=0", expq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)   begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
    checks++; if (rbusy !== 1'b0)  begin errors++; $display("FAIL rst_rbusy got=%b exp=0", rbusy); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
    checks++; if (count !== 6'd0)  begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== 15'd0) begin
      errors++;
      $display("FAIL rst_ram en=%b we=%b addr=%0d wdata=%h exp all 0", ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_push3();
    logic [4:0] wa[$];
    logic [7:0] wd[$];
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b1, 8'(i + 1), 1'b0);
      else       step(1'b0, 8'h00, 1'b0);
      if (s_we) begin wa.push_back(s_addr); wd.push_back(s_wdata); end
    end
    checks++;
    if (wa.size() != 3) begin
      errors++;
      $display("FAIL push3_nwrites got=%0d exp=3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa[i] !== 5'(i) || wd[i] !== 8'(i + 1)) begin
          errors++;
          $display("FAIL push3_write%0d addr=%0d data=%h exp addr=%0d data=%h", i, wa[i], wd[i], i, i + 1);
        end
      end
    end
    checks++; if (count !== 6'd3) begin errors++; $display("FAIL push3_count got=%0d exp=3", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL push3_empty got=%b exp=0", empty); end
    drain();
  endtask

  task automatic test_bypass();
    step(1'b1, 8'hA5, 1'b0);
    checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL byp_push_we got=%b exp=0", s_we); end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (s_en !== 1'b0 || s_we !== 1'b0 || s_pp !== 1'b1) begin
      errors++;
      $display("FAIL byp_grant en=%b we=%b accepted=%b exp 0 0 1", s_en, s_we, s_pp);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'hA5) begin
      errors++;
      $display("FAIL byp_rdata rvalid=%b rdata=%h exp 1 a5", rvalid, rdata);
    end
    checks++; if (s_en !== 1'b0) begin errors++; $display("FAIL byp_after_en got=%b exp=0", s_en); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL byp_count got=%0d exp=0", count); end
  endtask

  task automatic test_empty_pop();
    int rv0 = rv_events;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if (s_en !== 1'b0 || s_empty !== 1'b1) begin
        errors++;
        $display("FAIL epop_ram en=%b empty=%b exp 0 1", s_en, s_empty);
      end
    end
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++; if (rv_events != rv0) begin errors++; $display("FAIL epop_rvalid got=%0d exp=%0d", rv_events, rv0); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL epop_count got=%0d exp=0", count); end
  endtask

  task automatic test_stream();
    logic [7:0] v = 8'd9;
    int cmin = 99, cmax = 0;
    logic saw_rbusy = 1'b0, saw_force = 1'b0;
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++; if (count !== 6'd8) begin errors++; $display("FAIL stream_preload got=%0d exp=8", count); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, v, 1'b1);
      if (s_pa) v++;
      if (s_rbusy) saw_rbusy = 1'b1;
      if (s_rbusy && s_en && s_we) saw_force = 1'b1;
      if (int'(s_count) < cmin) cmin = int'(s_count);
      if (int'(s_count) > cmax) cmax = int'(s_count);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (!saw_rbusy) begin errors++; $display("FAIL stream_rbusy got=0 exp=1"); end
    checks++; if (!saw_force) begin errors++; $display("FAIL stream_force_wr got=0 exp=1"); end
    checks++;
    if (cmin < 6 || cmax > 10) begin
      errors++;
      $display("FAIL stream_count range got=%0d..%0d exp within 6..10", cmin, cmax);
    end
    drain();
  endtask

  task automatic test_full_wrap();
    int nw = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    drain();
    // Pointers now sit at 5, so the 32-entry pass must wrap 31 -> 0.
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b0);
      if (s_we) begin
        checks++;
        if (s_addr !== 5'((5 + nw) % 32)) begin
          errors++;
          $display("FAIL full_waddr got=%0d exp=%0d", s_addr, (5 + nw) % 32);
        end
        nw++;
      end
    end
    step(1'b1, 8'hEE, 1'b0);
    checks++; if (s_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", s_full); end
    checks++; if (s_count !== 6'd32) begin errors++; $display("FAIL full_count got=%0d exp=32", s_count); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL full_ignored count=%0d exp=32", count); end
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if (s_en !== 1'b1 || s_we !== 1'b0 || s_addr !== 5'((5 + k) % 32)) begin
        errors++;
        $display("FAIL full_raddr%0d en=%b we=%b addr=%0d exp 1 0 %0d", k, s_en, s_we, s_addr, (5 + k) % 32);
      end
    end
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got=%b exp=1", empty); end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL full_leftover got=%0d exp=0", expq.size()); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++; if (count !== 6'd5) begin errors++; $display("FAIL mid_count got=%0d exp=5", count); end
    step(1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #2;
    ren = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (rvalid !== 1'b0 || rdata !== 8'h00 || count !== 6'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst rvalid=%b rdata=%h count=%0d empty=%b exp 0 00 0 1", rvalid, rdata, count, empty);
    end
    checks++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0 || full !== 1'b0 || rbusy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_ctl en=%b we=%b full=%b rbusy=%b exp all 0", ram_en, ram_we, full, rbusy);
    end
    expq.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (s_we !== 1'b1 || s_addr !== 5'd0 || s_wdata !== 8'h77) begin
      errors++;
      $display("FAIL mid_first_write we=%b addr=%0d data=%h exp 1 0 77", s_we, s_addr, s_wdata);
    end
    drain();
  endtask

  initial begin
    wen = 1'b0; ren = 1'b0; wdata = 8'h00; rst = 1'b1;
    test_reset();
    test_push3();
    test_bypass();
    test_empty_pop();
    test_stream();
    test_full_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spram_fifo_sched.md
SPRAM_FIFO_SCHED -- requirements
Module: spram_fifo_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO entry width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, entry count, power of two.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(FIFO_DEPTH), RAM address width.
REQ-004 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: wen  in  1  push request; wdata  in  DATA_WIDTH  push data; full  out  1  push refused.
REQ-007 SHALL have port: ren  in  1  pop request; empty  out  1  no stored entries; rbusy  out  1  pop refused this cycle (RAM reserved for write).
REQ-008 SHALL have port: rdata  out  DATA_WIDTH  pop data; rvalid  out  1  rdata valid.
REQ-009 SHALL have port: count  out  ADDR_WIDTH+1  total entries held (RAM + write buffer).
REQ-010 SHALL have RAM port: ram_en, ram_we  out  1; ram_addr  out  ADDR_WIDTH; ram_wdata  out  DATA_WIDTH; ram_rdata  in  DATA_WIDTH (single-port RAM, 1-cycle sync read).

Function
REQ-011 SHALL accept a push iff wen && !full; full = (count==FIFO_DEPTH) || (wbuf_cnt==2).
REQ-012 SHALL place accepted push data into a 2-entry write buffer (wbuf); RAM holds older entries, wbuf newer.
REQ-013 SHALL accept a pop iff ren && !empty && !rbusy; empty = (count==0); rbusy = (wbuf_cnt==2) && (ram_cnt!=0).
REQ-014 SHALL grant the RAM once per cycle, priority: FORCE_WR (wbuf_cnt==2) > RD (pop accepted, ram_cnt!=0) > BYPASS (pop accepted, ram_cnt==0, served from wbuf head, no RAM access) > WR (wbuf_cnt!=0) > IDLE.
REQ-015 SHALL on RD drive ram_en=1, ram_we=0, ram_addr=rd_ptr; rd_ptr increments modulo FIFO_DEPTH.
REQ-016 SHALL on WR/FORCE_WR drive ram_en=1, ram_we=1, ram_addr=wr_ptr, ram_wdata=wbuf head; pop wbuf head; wr_ptr increments modulo FIFO_DEPTH.
REQ-017 SHALL assert rvalid exactly one cycle after each accepted pop; rdata = ram_rdata after RD, registered wbuf head after BYPASS; rdata undefined-but-stable-0 is not required when rvalid=0.
REQ-018 SHALL deliver data in strict push order across RAM, wbuf and bypass paths.
REQ-019 SHALL update count by +1 per accepted push, -1 per accepted pop, unchanged when both occur.
REQ-020 SHALL ignore wen when full and ren when empty or rbusy, with no state change.
REQ-021 SHALL keep ram_en=0, ram_we=0 in IDLE and BYPASS cycles.

Reset
REQ-022 SHALL while rst=1 force empty=1, full=0, rbusy=0, rvalid=0, rdata=0, count=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-023 SHALL clear rd_ptr, wr_ptr, ram_cnt, wbuf contents/count and any pending rvalid on rst, including mid-operation.
REQ-024 SHALL resume normal operation on the first rising edge after rst deasserts.

Structure
REQ-025 SHALL define in package spram_fifo_pkg: grant_e enum {IDLE, RD, BYPASS, WR, FORCE_WR}.
REQ-026 SHALL implement the 2-entry write buffer as sub-module spram_fifo_wbuf (push/pop/head/cnt).
REQ-027 SHALL keep arbiter grant combinational from registered state and inputs; pointers, counts, rvalid, bypass register sequential.

Verification
REQ-028 SHALL cover: push 1,2,3 on consecutive cycles, no pops -> ram_we at addr 0,1,2, count=3, empty=0.
REQ-029 SHALL cover: push 0xA5 into empty FIFO, ren next cycle -> BYPASS, rvalid=1 with rdata=0xA5 following cycle, no ram_we for that entry.
REQ-030 SHALL cover: preload 8, then wen+ren every cycle for 10 cycles -> rbusy pulses when wbuf_cnt==2, FORCE_WR granted, popped data 1..N in order, count stays 8±2.
REQ-031 SHALL cover: push 32 -> full=1, count=32, 33rd wen ignored; pop 32 -> rd_ptr wraps 31->0, data in order, empty=1.
REQ-032 SHALL cover: rst asserted with count=5 and pop in flight -> all outputs at reset values immediately; next push written to addr 0.
REQ-033 SHALL cover: ren on empty FIFO -> no rvalid, no RAM access, count stays 0.
